// File: rtl/led_display_pattern_gen.sv
// led_display_pattern_gen: test-pattern source that streams LED matrix row pairs
// (upper row y, lower row y+NUM_ROW_PIXELS/2) over a valid/ready handshake.
// Optional build macro PATTERN_GEN_SCROLL_EN: stripe and checkerboard patterns
// scroll one column per animation step.
module led_display_pattern_gen #(
    parameter int unsigned SYS_CLK_FREQ   = 100_000_000,
    parameter int unsigned NUM_ROW_PIXELS = 32,
    parameter int unsigned NUM_COL_PIXELS = 64,
    parameter int unsigned STEP_HZ        = 4
) (
    input  logic                        clk_in,
    input  logic                        n_reset_in,
    input  logic [3:0]                  mode_in,
    output logic [6*NUM_COL_PIXELS-1:0] row_out,
    output logic                        row_valid_out,
    input  logic                        row_ready_in
);

    localparam int unsigned N           = NUM_COL_PIXELS;
    localparam int unsigned PAIR_W      = 6 * N;
    localparam int unsigned HALF_ROWS   = NUM_ROW_PIXELS / 2;
    localparam int unsigned Y_W         = (HALF_ROWS > 1) ? $clog2(HALF_ROWS) : 1;
    localparam int unsigned STEP_P      = SYS_CLK_FREQ / STEP_HZ;
    localparam int unsigned CNT_W       = (STEP_P > 1) ? $clog2(STEP_P) : 1;
    localparam int unsigned S_W         = 3;
    localparam int unsigned NUM_COLOURS = 7;
    localparam int unsigned O_W         = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              load_c;
    logic [Y_W-1:0]    y;
    logic [Y_W-1:0]    y_load_c;
    logic [CNT_W-1:0]  step_cnt;
    logic [S_W-1:0]    step_idx;
    logic              step_tick_c;
    logic [2:0]        colour_c;
    logic [2:0]        rgb_c;
    logic [PAIR_W-1:0] pair_c;
    int unsigned       row_abs_c;
    int unsigned       col_c;
    int unsigned       ofs_c;

    assign step_tick_c = (step_cnt == CNT_W'(STEP_P - 1));

    // Free-running animation divider; step index cycles through the seven colours
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            step_cnt <= '0;
            step_idx <= '0;
        end else if (step_tick_c) begin
            step_cnt <= '0;
            step_idx <= (step_idx == S_W'(NUM_COLOURS - 1)) ? '0 : step_idx + S_W'(1);
        end else begin
            step_cnt <= step_cnt + CNT_W'(1);
        end
    end

`ifdef PATTERN_GEN_SCROLL_EN
    logic [O_W-1:0] col_ofs;

    // Horizontal scroll offset, one column per animation step
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            col_ofs <= '0;
        end else if (step_tick_c) begin
            col_ofs <= (col_ofs == O_W'(N - 1)) ? '0 : col_ofs + O_W'(1);
        end
    end

    assign ofs_c = 32'(col_ofs);
`else
    assign ofs_c = 32'd0;
`endif

    // State register: idle until the first row has been loaded after reset
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Load decision and which row pair to load
    always_comb begin
        load_c   = 1'b0;
        y_load_c = y;
        case (state)
            ST_IDLE: begin
                load_c   = 1'b1;
                y_load_c = '0;
            end
            ST_RUN: begin
                if (row_ready_in) begin
                    load_c   = 1'b1;
                    y_load_c = (y == Y_W'(HALF_ROWS - 1)) ? '0 : y + Y_W'(1);
                end
            end
            default: begin
                load_c   = 1'b0;
                y_load_c = y;
            end
        endcase
    end

    // Colour-cycle lookup, bit0=red bit1=green bit2=blue
    always_comb begin
        colour_c = 3'b000;
        case (step_idx)
            3'd0:    colour_c = 3'b001;
            3'd1:    colour_c = 3'b010;
            3'd2:    colour_c = 3'b100;
            3'd3:    colour_c = 3'b011;
            3'd4:    colour_c = 3'b110;
            3'd5:    colour_c = 3'b101;
            3'd6:    colour_c = 3'b111;
            default: colour_c = 3'b000;
        endcase
    end

    // Pattern generator for the row pair about to be loaded
    always_comb begin
        pair_c    = '0;
        row_abs_c = 32'd0;
        col_c     = 32'd0;
        rgb_c     = 3'b000;
        for (int unsigned half = 0; half < 2; half++) begin
            row_abs_c = 32'(y_load_c) + half * HALF_ROWS;
            for (int unsigned c = 0; c < N; c++) begin
                col_c = c + ofs_c;
                if (col_c >= N) begin
                    col_c = col_c - N;
                end
                case (mode_in)
                    4'd1:    rgb_c = 3'b001;
                    4'd2:    rgb_c = 3'b010;
                    4'd3:    rgb_c = 3'b100;
                    4'd4:    rgb_c = 3'b111;
                    4'd5:    rgb_c = (((col_c >> 2) & 32'd1) == 32'd0) ? 3'b111 : 3'b000;
                    4'd6:    rgb_c = ((((col_c ^ row_abs_c) >> 2) & 32'd1) == 32'd0) ? 3'b111 : 3'b000;
                    4'd7:    rgb_c = colour_c;
                    default: rgb_c = 3'b000;
                endcase
                for (int unsigned p = 0; p < 3; p++) begin
                    pair_c = pair_c | (PAIR_W'(rgb_c[p]) << ((half * 3 + p) * N + c));
                end
            end
        end
    end

    // Output registers: row pair, valid flag and row counter update on each load
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            row_out       <= '0;
            row_valid_out <= 1'b0;
            y             <= '0;
        end else if (load_c) begin
            row_out       <= pair_c;
            row_valid_out <= 1'b1;
            y             <= y_load_c;
        end
    end

endmodule

// File: tb/tb_led_display_pattern_gen.sv
// tb_led_display_pattern_gen: directed plus randomized checks of the pattern
// generator against a transaction-level reference model.
module tb_led_display_pattern_gen;

    localparam int unsigned SYS_HZ = 100;
    localparam int unsigned STEP   = 10;
    localparam int unsigned P      = SYS_HZ / STEP;
    localparam int unsigned NR     = 32;
    localparam int unsigned NC     = 64;
    localparam int unsigned HALF   = NR / 2;
    localparam int unsigned PW     = 6 * NC;

    logic          clk_in = 1'b0;
    logic          n_reset_in;
    logic [3:0]    mode_in;
    logic          row_ready_in;
    logic [PW-1:0] row_out;
    logic          row_valid_out;

    int            n_checks = 0;
    int            n_fails  = 0;

    // Model state: edges since reset release, current row index, loaded pair
    int unsigned   k;
    int unsigned   m_y;
    logic          m_valid;
    logic [PW-1:0] m_row;

    always #5 clk_in = ~clk_in;

    led_display_pattern_gen #(
        .SYS_CLK_FREQ  (SYS_HZ),
        .NUM_ROW_PIXELS(NR),
        .NUM_COL_PIXELS(NC),
        .STEP_HZ       (STEP)
    ) dut (
        .clk_in       (clk_in),
        .n_reset_in   (n_reset_in),
        .mode_in      (mode_in),
        .row_out      (row_out),
        .row_valid_out(row_valid_out),
        .row_ready_in (row_ready_in)
    );

    function automatic int unsigned scroll_ofs(int unsigned edge_no);
`ifdef PATTERN_GEN_SCROLL_EN
        return ((edge_no - 1) / P) % NC;
`else
        return 0;
`endif
    endfunction

    // Pixel colour {b,g,r} for absolute row yy and column c
    function automatic logic [2:0] pixel(int unsigned mode, int unsigned yy, int unsigned c,
                                         int unsigned s, int unsigned o);
        int unsigned tbl [7];
        int unsigned cc;
        tbl = '{1, 2, 4, 3, 6, 5, 7};
        cc  = (c + o) % NC;
        case (mode)
            1:       return 3'd1;
            2:       return 3'd2;
            3:       return 3'd4;
            4:       return 3'd7;
            5:       return ((cc % 8) < 4) ? 3'd7 : 3'd0;
            6:       return (((cc / 4) + (yy / 4)) % 2 == 0) ? 3'd7 : 3'd0;
            7:       return 3'(tbl[s]);
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [PW-1:0] model_pair(int unsigned mode, int unsigned yrow,
                                                 int unsigned s, int unsigned o);
        logic [PW-1:0] r;
        logic [2:0]    px;
        r = '0;
        for (int unsigned h = 0; h < 2; h++) begin
            for (int unsigned c = 0; c < NC; c++) begin
                px = pixel(mode, yrow + h * HALF, c, s, o);
                for (int unsigned p = 0; p < 3; p++) begin
                    r[(h * 3 + p) * NC + c] = px[p];
                end
            end
        end
        return r;
    endfunction

    task automatic check_row(input string tag, input logic [PW-1:0] exp);
        n_checks++;
        assert (row_out === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, row_out, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; called at posedge+1, returns at posedge+1
    task automatic step(input string tag, input int unsigned mode, input logic ready);
        mode_in      = 4'(mode);
        row_ready_in = ready;
        @(posedge clk_in);
        k++;
        if (!m_valid || ready) begin
            if (m_valid) m_y = (m_y + 1) % HALF;
            m_row   = model_pair(mode, m_y, ((k - 1) / P) % 7, scroll_ofs(k));
            m_valid = 1'b1;
        end
        #1;
        check_bit({tag, "_valid"}, row_valid_out, m_valid);
        check_row(tag, m_row);
    endtask

    task automatic model_reset();
        k       = 0;
        m_y     = 0;
        m_valid = 1'b0;
        m_row   = '0;
    endtask

    initial begin
        logic [PW-1:0] ones;
        logic [PW-1:0] stripe;
        logic [PW-1:0] stripe_inv;
        logic [63:0]   pat;
        ones = '1;
        pat  = 64'h0F0F_0F0F_0F0F_0F0F;
        stripe     = {6{pat}};
        stripe_inv = ~stripe;

        n_reset_in   = 1'b0;
        mode_in      = 4'd0;
        row_ready_in = 1'b1;
        model_reset();
        repeat (3) @(posedge clk_in);
        #1;
        check_bit("reset_valid", row_valid_out, 1'b0);
        check_row("reset_row", '0);

        // Release away from the clock edge; first edge loads pair 0
        n_reset_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step("mode0", 0, 1'b1);
            check_row("mode0_zero", '0);
        end

        for (int m = 1; m <= 4; m++) begin
            for (int i = 0; i < 100; i++) step("solid", m, 1'b1);
        end

        for (int i = 0; i < 20; i++) begin
            step("stripe", 5, 1'b1);
            if (scroll_ofs(k) == 0) check_row("stripe_const", stripe);
        end

        for (int i = 0; i < 40; i++) begin
            step("checker", 6, 1'b1);
            if (scroll_ofs(k) == 0 && m_y == 0) check_row("checker_y0", stripe);
            if (scroll_ofs(k) == 0 && m_y == 4) check_row("checker_y4", stripe_inv);
        end

        // Stall: row and row counter hold while mode changes underneath
        for (int i = 0; i < 3; i++) step("stall_pre", 4, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step("stall", 0, 1'b0);
            check_row("stall_hold", ones);
        end
        step("stall_release", 0, 1'b1);
        check_row("stall_release_zero", '0);

        for (int i = 0; i < 150; i++) step("cycle", 7, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            step("random", $urandom_range(0, 15), 1'(($urandom % 4) != 0));
        end

        // Asynchronous reset in the middle of a cycle
        #2;
        n_reset_in = 1'b0;
        #1;
        check_bit("midreset_valid", row_valid_out, 1'b0);
        check_row("midreset_row", '0);
        @(posedge clk_in);
        #1;
        check_bit("midreset_hold_valid", row_valid_out, 1'b0);
        model_reset();
        n_reset_in = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step("post_reset", $urandom_range(0, 7), 1'(($urandom % 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
